// File: rtl/tmr_lane_driver.sv
// tmr_lane_driver: replicates handshaked words onto three TMR lanes and periodically runs an 8-vector checker self-test
module tmr_lane_driver #(
   parameter int WIDTH = 8,
   parameter int TEST_PERIOD = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c0,
   output logic [WIDTH-1:0] c1,
   output logic [WIDTH-1:0] c2,
   input  logic [WIDTH-1:0] cout_in,
   input  logic             force_test,
   output logic             test_active,
   output logic             test_done,
   output logic             selftest_fail,
   output logic [2:0]       fail_vec
);
   localparam int CW = TEST_PERIOD > 1 ? $clog2(TEST_PERIOD) : 1;
   typedef enum logic [1:0] {IDLE, DRAIN, TEST} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0] k;
   logic pending, accept, wrap, last;
   logic [WIDTH-1:0] data_q, exp_cout;
   assign in_ready = !reset && state == IDLE && !pending && (!out_valid || out_ready);
   assign accept = in_valid && in_ready;
   assign wrap = cnt == CW'(TEST_PERIOD - 1);
   assign last = state == TEST && k == 3'd7;
   assign test_active = state == TEST;
   assign exp_cout = (k == 3'd1 || k == 3'd2 || k == 3'd4) ? '0 : '1;
   assign c0 = test_active ? {WIDTH{k[0]}} : data_q;
   assign c1 = test_active ? {WIDTH{k[1]}} : data_q;
   assign c2 = test_active ? {WIDTH{k[2]}} : data_q;
   always_comb begin
      state_n = state;
      state_n = state == IDLE  ? (pending ? DRAIN : IDLE) :
                state == DRAIN ? (out_valid ? DRAIN : TEST) :
                                 (k == 3'd7 ? IDLE : TEST);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         k <= '0;
         pending <= 1'b0;
         data_q <= '0;
         out_valid <= 1'b0;
         test_done <= 1'b0;
         selftest_fail <= 1'b0;
         fail_vec <= '0;
      end else begin
         state <= state_n;
         k <= state == TEST ? k + 3'd1 : 3'd0;
         test_done <= last;
         if (accept) begin
            data_q <= in_data;
            out_valid <= 1'b1;
            cnt <= wrap ? '0 : cnt + CW'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (last) data_q <= '0;
         if (last) pending <= 1'b0;
         else if ((accept && wrap) || (force_test && state != TEST)) pending <= 1'b1;
         if (state == TEST && cout_in != exp_cout) begin
            selftest_fail <= 1'b1;
            if (!selftest_fail) fail_vec <= k;
         end
      end
   end
endmodule

// File: tb/tb_tmr_lane_driver.sv
// tb_tmr_lane_driver: randomized and directed check of tmr_lane_driver against a transaction-level model
module tb_tmr_lane_driver;
   localparam int W = 8;
   localparam int TP = 4;
   logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, force_test = 0;
   logic [W-1:0] in_data = '0;
   logic in_ready, out_valid, test_active, test_done, selftest_fail;
   logic [W-1:0] c0, c1, c2, cout_in;
   logic [2:0] fail_vec;
   int md = 0;
   int checks = 0, failures = 0;
   logic [W-1:0] m_word = '0;
   bit m_vld = 0, m_pend = 0, m_drain = 0, m_done = 0, m_fail = 0, exp_rdy;
   int m_cnt = 0, m_k = -1;
   logic [2:0] m_fvec = '0;
   always #5 clk = ~clk;
   function automatic logic [W-1:0] checker_fn(int m, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
      return m == 1 ? '1 : m == 2 ? '0 : ~((a ^ b ^ c) & ~(a & b & c));
   endfunction
   assign cout_in = checker_fn(md, c0, c1, c2);
   tmr_lane_driver #(.WIDTH(W), .TEST_PERIOD(TP)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .c0(c0), .c1(c1), .c2(c2), .cout_in(cout_in),
      .force_test(force_test), .test_active(test_active), .test_done(test_done),
      .selftest_fail(selftest_fail), .fail_vec(fail_vec)
   );
   function automatic logic [W-1:0] lane(int i);
      logic [2:0] kk;
      kk = 3'(m_k);
      return m_k >= 0 ? {W{kk[i]}} : m_word;
   endfunction
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
      end
   endtask
   task automatic step(bit r, bit iv, logic [W-1:0] d, bit ordy, bit ft);
      bit acc;
      int old_k;
      bit old_vld;
      logic [W-1:0] cv, ev;
      reset = r; in_valid = iv; in_data = d; out_ready = ordy; force_test = ft;
      #1;
      exp_rdy = !r && !m_pend && (!m_vld || ordy);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
      chk("c0", 32'(c0), 32'(lane(0)));
      chk("c1", 32'(c1), 32'(lane(1)));
      chk("c2", 32'(c2), 32'(lane(2)));
      chk("test_active", {31'd0, test_active}, {31'd0, m_k >= 0});
      chk("test_done", {31'd0, test_done}, {31'd0, m_done});
      chk("selftest_fail", {31'd0, selftest_fail}, {31'd0, m_fail});
      chk("fail_vec", 32'(fail_vec), 32'(m_fvec));
      @(posedge clk);
      if (r) begin
         m_word = '0; m_vld = 0; m_pend = 0; m_drain = 0; m_done = 0; m_fail = 0;
         m_cnt = 0; m_k = -1; m_fvec = '0;
      end else begin
         acc = iv && exp_rdy;
         old_k = m_k;
         old_vld = m_vld;
         if (m_k >= 0) begin
            cv = checker_fn(md, lane(0), lane(1), lane(2));
            ev = $countones(3'(m_k)) == 1 ? '0 : '1;
            if (cv !== ev) begin
               if (!m_fail) m_fvec = 3'(m_k);
               m_fail = 1;
            end
         end
         m_done = old_k == 7;
         if (old_k == 7) begin
            m_k = -1; m_pend = 0; m_word = '0;
         end else if (old_k >= 0) m_k++;
         else if (m_drain && !old_vld) begin
            m_drain = 0; m_k = 0;
         end else if (m_pend && !m_drain) m_drain = 1;
         if (acc) begin
            m_word = d; m_vld = 1; m_cnt++;
            if (m_cnt == TP) begin
               m_cnt = 0; m_pend = 1;
            end
         end else if (ordy) m_vld = 0;
         if (ft && old_k < 0) m_pend = 1;
      end
      #1;
   endtask
   task automatic wait_test();
      for (int i = 0; i < 20 && !test_active; i++) step(0, 0, '0, 1, 0);
      chk("reach_test", {31'd0, test_active}, 32'd1);
   endtask
   task automatic run_forced_test();
      step(0, 0, '0, 1, 1);
      wait_test();
      for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);
      chk("done_pulse", {31'd0, test_done}, 32'd1);
   endtask
   initial begin
      logic [2:0] kk;
      @(posedge clk); #1;
      step(1, 0, '0, 0, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_c0", 32'(c0), 32'd0);
      step(0, 1, 8'hA5, 1, 0);
      chk("lane_a5_c0", 32'(c0), 32'hA5);
      chk("lane_a5_c2", 32'(c2), 32'hA5);
      step(0, 1, 8'h3C, 1, 0);
      chk("lane_3c_c1", 32'(c1), 32'h3C);
      step(0, 1, 8'h11, 0, 0);
      chk("hold_rdy", {31'd0, in_ready}, 32'd0);
      chk("hold_lane", 32'(c0), 32'h3C);
      step(0, 1, 8'h11, 1, 0);
      chk("release_lane", 32'(c0), 32'h11);
      step(0, 1, 8'h22, 1, 0);
      chk("pend_blocks", {31'd0, in_ready}, 32'd0);
      wait_test();
      for (int i = 0; i < 8; i++) begin
         kk = 3'(i);
         chk("vec_c0", 32'(c0), 32'({W{kk[0]}}));
         chk("vec_c1", 32'(c1), 32'({W{kk[1]}}));
         chk("vec_c2", 32'(c2), 32'({W{kk[2]}}));
         chk("vec_ov", {31'd0, out_valid}, 32'd0);
         step(0, 1, 8'h33, 1, 0);
      end
      chk("auto_done", {31'd0, test_done}, 32'd1);
      chk("auto_active", {31'd0, test_active}, 32'd0);
      chk("auto_resume", {31'd0, in_ready}, 32'd1);
      chk("auto_clean", {31'd0, selftest_fail}, 32'd0);
      run_forced_test();
      chk("good_checker", {31'd0, selftest_fail}, 32'd0);
      md = 1;
      run_forced_test();
      chk("stuck_fail", {31'd0, selftest_fail}, 32'd1);
      chk("stuck_vec", 32'(fail_vec), 32'd1);
      md = 2;
      run_forced_test();
      chk("second_vec", 32'(fail_vec), 32'd1);
      md = 0;
      step(0, 0, '0, 1, 1);
      wait_test();
      for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
      chk("at_k3", 32'(c0), 32'hFF);
      step(1, 0, '0, 1, 0);
      chk("abort_active", {31'd0, test_active}, 32'd0);
      chk("abort_fail", {31'd0, selftest_fail}, 32'd0);
      chk("abort_vec", 32'(fail_vec), 32'd0);
      chk("abort_c1", 32'(c1), 32'd0);
      reset = 0; in_valid = 1; out_ready = 1;
      #1;
      chk("rdy_after_rst", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 49) == 0) md = $urandom_range(0, 2);
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, W'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
